// File: rtl/gpio_hex_display_if.sv
// CPU-side GPIO write port and scan-display outputs of the hex display block.
interface gpio_hex_display_if;
    logic        gpio_we;
    logic [31:0] gpio_data;
    logic [31:0] value_out;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_pulse;

    modport master (
        output gpio_we, gpio_data,
        input  value_out, an, seg, frame_pulse
    );

    modport slave (
        input  gpio_we, gpio_data,
        output value_out, an, seg, frame_pulse
    );
endinterface

// File: rtl/gpio_hex_display.sv
// 8-digit multiplexed hex display fed by a CPU GPIO word, committed only at frame boundaries.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module gpio_hex_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    gpio_hex_display_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] counter_reg;
    logic [2:0]       idx_reg;
    logic [31:0]      shadow_reg;
    logic             pending_reg;
    logic [31:0]      display_reg;
    logic             frame_pulse_reg;
    logic [7:0]       an_reg;
    logic [6:0]       seg_reg;

    logic             tick;
    logic             frame;
    logic [2:0]       idx_next;
    logic [31:0]      display_next;
    logic [6:0]       seg_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick  = (counter_reg == CNT_LAST);
    assign frame = tick && (idx_reg == 3'd7);

    // an/seg are computed from the post-edge index and display so they move together with idx.
    assign idx_next     = tick ? idx_reg + 3'd1 : idx_reg;
    assign display_next = (frame && pending_reg) ? shadow_reg : display_reg;

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] nz;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nz
            assign nz[gi] = |display_next[4*gi +: 4];
        end
    endgenerate

    // Digit 0 always shows, so an all-zero display still reads "0".
    always_comb begin
        seg_next = hex_decode(display_next[4*idx_next +: 4]);
        if ((idx_next != 3'd0) && ((nz >> idx_next) == 8'd0))
            seg_next = 7'b1111111;
    end
`else
    always_comb begin
        seg_next = hex_decode(display_next[4*idx_next +: 4]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg     <= '0;
            idx_reg         <= 3'd0;
            shadow_reg      <= 32'd0;
            pending_reg     <= 1'b0;
            display_reg     <= 32'd0;
            frame_pulse_reg <= 1'b0;
            an_reg          <= 8'hFE;
            seg_reg         <= 7'b1000000;
        end else begin
            counter_reg     <= tick ? '0 : counter_reg + CNT_W'(1);
            idx_reg         <= idx_next;
            display_reg     <= display_next;
            frame_pulse_reg <= frame;
            if (bus.gpio_we)
                shadow_reg <= bus.gpio_data;
            // A write landing on the boundary keeps pending set: it is committed next frame.
            if (bus.gpio_we)
                pending_reg <= 1'b1;
            else if (frame)
                pending_reg <= 1'b0;
            if (tick) begin
                an_reg  <= ~(8'd1 << idx_next);
                seg_reg <= seg_next;
            end
        end
    end

    assign bus.value_out   = display_reg;
    assign bus.an          = an_reg;
    assign bus.seg         = seg_reg;
    assign bus.frame_pulse = frame_pulse_reg;
endmodule

// File: tb/tb_gpio_hex_display.sv
// Directed, table-driven check of gpio_hex_display with REFRESH_DIV=4 (tick every 4 cycles, frame every 32).
module tb_gpio_hex_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    gpio_hex_display_if bus ();

    gpio_hex_display #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          adv;
        bit          we;
        logic [31:0] data;
        logic [31:0] val;
        logic [7:0]  an;
        logic [6:0]  seg;
        bit          fp;
    } vec_t;

    vec_t vecs[13];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_LZ = 7'b1111111;
`else
    localparam logic [6:0] SEG_LZ = 7'b1000000;
`endif

    task automatic check(input string name, input logic [31:0] val, input logic [7:0] an,
                         input logic [6:0] seg, input bit fp);
        n_checks += 4;
        if (bus.value_out !== val) begin
            n_fail++;
            $display("FAIL %s value_out got %h want %h", name, bus.value_out, val);
        end
        if (bus.an !== an) begin
            n_fail++;
            $display("FAIL %s an got %h want %h", name, bus.an, an);
        end
        if (bus.seg !== seg) begin
            n_fail++;
            $display("FAIL %s seg got %b want %b", name, bus.seg, seg);
        end
        if (bus.frame_pulse !== fp) begin
            n_fail++;
            $display("FAIL %s frame_pulse got %b want %b", name, bus.frame_pulse, fp);
        end
        $display("txn %s: value=%h an=%h seg=%b fp=%b", name, bus.value_out, bus.an, bus.seg,
                 bus.frame_pulse);
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            bus.gpio_we = 1'b0;
        end
    endtask

    initial begin
        // t = edges since reset release; ticks at multiples of 4, boundaries at multiples of 32
        vecs[0]  = '{4,  1'b0, 32'h0,        32'h0,        8'hFD, 7'b1000000, 1'b0}; // t=4
        vecs[1]  = '{28, 1'b0, 32'h0,        32'h0,        8'hFE, 7'b1000000, 1'b1}; // t=32
        vecs[2]  = '{1,  1'b0, 32'h0,        32'h0,        8'hFE, 7'b1000000, 1'b0}; // t=33
        vecs[3]  = '{1,  1'b1, 32'h1234ABCD, 32'h0,        8'hFE, 7'b1000000, 1'b0}; // t=34
        vecs[4]  = '{30, 1'b0, 32'h0,        32'h1234ABCD, 8'hFE, 7'b0100001, 1'b1}; // t=64
        vecs[5]  = '{28, 1'b0, 32'h0,        32'h1234ABCD, 8'h7F, 7'b1111001, 1'b0}; // t=92
        vecs[6]  = '{4,  1'b0, 32'h0,        32'h1234ABCD, 8'hFE, 7'b0100001, 1'b1}; // t=96
        vecs[7]  = '{1,  1'b1, 32'h11111111, 32'h1234ABCD, 8'hFE, 7'b0100001, 1'b0}; // t=97
        vecs[8]  = '{31, 1'b1, 32'h22222222, 32'h22222222, 8'hFE, 7'b0100100, 1'b1}; // t=128
        vecs[9]  = '{31, 1'b1, 32'h33333333, 32'h22222222, 8'h7F, 7'b0100100, 1'b0}; // t=159
        vecs[10] = '{1,  1'b1, 32'h0000000F, 32'h33333333, 8'hFE, 7'b0110000, 1'b1}; // t=160
        vecs[11] = '{32, 1'b0, 32'h0,        32'h0000000F, 8'hFE, 7'b0001110, 1'b1}; // t=192
        vecs[12] = '{28, 1'b0, 32'h0,        32'h0000000F, 8'h7F, SEG_LZ,     1'b0}; // t=220

        bus.gpio_we   = 1'b1;
        bus.gpio_data = 32'hDEADBEEF;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.gpio_we = 1'b0;
        check("reset", 32'h0, 8'hFE, 7'b1000000, 1'b0);

        for (int i = 0; i < 13; i++) begin
            bus.gpio_we   = vecs[i].we;
            bus.gpio_data = vecs[i].data;
            advance(vecs[i].adv);
            check($sformatf("vec%0d", i), vecs[i].val, vecs[i].an, vecs[i].seg, vecs[i].fp);
        end

        // Pending write, then reset with a coincident write: neither may ever be committed.
        bus.gpio_we   = 1'b1;
        bus.gpio_data = 32'hAAAAAAAA;
        advance(1);
        rst           = 1'b1;
        bus.gpio_we   = 1'b1;
        bus.gpio_data = 32'h55555555;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.gpio_we = 1'b0;
        check("rst_mid", 32'h0, 8'hFE, 7'b1000000, 1'b0);
        advance(32);
        check("rst_boundary", 32'h0, 8'hFE, 7'b1000000, 1'b1);

        // Short value exercises leading-digit behaviour.
        bus.gpio_we   = 1'b1;
        bus.gpio_data = 32'h000000A5;
        advance(32);
        check("a5_dig0", 32'h000000A5, 8'hFE, 7'b0010010, 1'b1);
        advance(4);
        check("a5_dig1", 32'h000000A5, 8'hFD, 7'b0001000, 1'b0);
        advance(4);
        check("a5_dig2", 32'h000000A5, 8'hFB, SEG_LZ, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_hex_display.md
GPIO_HEX_DISPLAY -- requirements
Module: gpio_hex_display

Interface
REQ-001: Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles per digit slot; legal range 1..2^20.
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004: gpio_we  input  1  SHALL be the CPU GPIO write strobe, valid for one cycle per write.
REQ-005: gpio_data  input  32  SHALL be the CPU GPIO output word (io2_out), sampled when gpio_we=1.
REQ-006: value_out  output  32  SHALL be the committed value currently being displayed.
REQ-007: an  output  8  SHALL be the digit enables, active-low, exactly one bit low at any time.
REQ-008: seg  output  7  SHALL be the segment drives, active-low, seg[0]=a .. seg[6]=g.
REQ-009: frame_pulse  output  1  SHALL pulse high for one cycle at every frame boundary.

Function
REQ-010: Shadow capture: gpio_we=1 SHALL load shadow<=gpio_data and set pending<=1 on that edge; back-to-back writes, last write wins.
REQ-011: Divider: counter SHALL count 0..REFRESH_DIV-1 then wrap to 0; the wrap edge is a "tick".
REQ-012: On each tick, digit index SHALL advance idx<=(idx+1) mod 8.
REQ-013: Frame boundary SHALL be the tick where idx wraps 7->0; frame_pulse=1 in the cycle after that edge only.
REQ-014: At a frame boundary with pending=1, display SHALL load the pre-edge shadow value and pending SHALL clear; with pending=0, display SHALL hold.
REQ-015: gpio_we=1 coincident with a frame boundary: commit SHALL use the old shadow, the new word SHALL load shadow, and pending SHALL stay 1 (set wins over clear); the new word is committed at the next boundary.
REQ-016: Display SHALL change only at frame boundaries: no partial-frame (torn) values.
REQ-017: an and seg SHALL be registered and SHALL update on the same edge as idx; an = ~(1<<idx) and seg = hexdecode(display[4*idx+3:4*idx]), both using the post-edge idx and display.
REQ-018: Hex decode (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019: value_out SHALL equal the display register.
REQ-020: With REFRESH_DIV=1, every cycle SHALL be a tick; a full frame is 8 cycles.

Reset
REQ-021: rst=1 SHALL force counter=0, idx=0, shadow=0, pending=0, display=0, frame_pulse=0, an=8'hFE, seg=7'b1000000, value_out=0.
REQ-022: rst SHALL take priority over gpio_we and ticks; a write in the reset cycle is discarded.
REQ-023: After rst deasserts, the first tick SHALL occur REFRESH_DIV cycles later, and the first frame boundary 8*REFRESH_DIV cycles later.
REQ-024: rst asserted mid-frame SHALL abandon the frame and discard any pending write.

Configuration
REQ-025: Macro LEADING_ZERO_BLANK_EN defined: digit positions above the most significant nonzero nibble of display SHALL output seg=7'b1111111, with the an scan unchanged; digit 0 is never blanked (display=0 shows "0").
REQ-026: Macro LEADING_ZERO_BLANK_EN undefined: all 8 digits SHALL always be decoded per REQ-018.

Verification
REQ-027: Reset, REFRESH_DIV=4 -> an=FE and seg=1000000 on reset exit; an=FD after 4 cycles; frame_pulse after 32 cycles; value_out=0.
REQ-028: gpio_we with 32'h1234ABCD mid-frame -> value_out unchanged until the next boundary, then 1234ABCD; digit 0 shows D (0100001), digit 7 shows 1 (1111001).
REQ-029: Writes 32'h11111111 then 32'h22222222 on consecutive cycles within one frame -> only 22222222 is committed at the boundary.
REQ-030: Write 32'h0000000F on the boundary edge -> value_out keeps the old value for that frame and becomes 0000000F one frame later.
REQ-031: rst pulsed with a write pending -> value_out=0 and the pending write is never committed.
REQ-032: With LEADING_ZERO_BLANK_EN defined, display=32'h000000A5 -> digits 0,1 show 5 and A; digits 2..7 show seg=1111111; display=0 -> digit 0 shows 0.
